// File: rtl/sd_wb_dma.sv
// rtl/sd_wb_dma.sv - block DMA between SD data buffers and a Wishbone master port
// Moves one 2^BUF_AW-word block per request as a train of fixed-length incrementing bursts.
module sd_wb_dma #(
    parameter int BUF_AW    = 7,
    parameter int BURST_LEN = 8,
    parameter int TMO_W     = 8
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [31:0]       rd_addr,
    input  logic              wr_req,
    input  logic [31:0]       wr_addr,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BUF_AW-1:0] bufr_addr,
    output logic              bufr_wren,
    output logic [31:0]       bufr_data,
    output logic [BUF_AW-1:0] bufw_addr,
    input  logic [31:0]       bufw_q,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    output logic [3:0]        wbm_sel_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic [2:0]        wbm_cti_o,
    output logic [1:0]        wbm_bte_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_BURST,
        S_GAP,
        S_FIN
    } state_t;

    localparam logic [31:0]       BASE_MASK = ~((32'd1 << (BUF_AW + 2)) - 32'd1);
    localparam logic [BUF_AW:0]   BEAT_MASK = (BUF_AW + 1)'(BURST_LEN - 1);
    localparam logic [BUF_AW-1:0] BLK_LAST  = '1;
    localparam logic [TMO_W-1:0]  TMO_MAX   = '1;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       base;
    logic [BUF_AW:0]   idx;
    logic              is_wr;
    logic [TMO_W-1:0]  tmo;

    logic start;
    logic in_burst;
    logic bus_fault;
    logic beat_ok;
    logic burst_end;
    logic block_end;

    // Abort outranks every bus response; a fault outranks an ack in the same cycle.
    assign start     = (state == S_IDLE) && (rd_req || wr_req);
    assign in_burst  = (state == S_BURST);
    assign bus_fault = in_burst && !abort && (wbm_err_i || (tmo == TMO_MAX));
    assign beat_ok   = in_burst && !abort && !bus_fault && wbm_ack_i;
    assign burst_end = (idx & BEAT_MASK) == BEAT_MASK;
    assign block_end = (idx[BUF_AW-1:0] == BLK_LAST);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PREP;
            S_PREP:  state_nxt = S_BURST;
            S_BURST: begin
                if (bus_fault) begin
                    state_nxt = S_FIN;
                end else if (beat_ok && burst_end) begin
                    state_nxt = block_end ? S_FIN : S_GAP;
                end
            end
            S_GAP:   state_nxt = S_PREP;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if ((state != S_IDLE) && abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            base  <= '0;
            idx   <= '0;
            is_wr <= 1'b0;
            err   <= 1'b0;
            tmo   <= '0;
        end else begin
            if (start) begin
                base  <= (wr_req ? wr_addr : rd_addr) & BASE_MASK;
                is_wr <= wr_req;
                idx   <= '0;
                err   <= 1'b0;
            end
            if (beat_ok) begin
                idx <= idx + 1'b1;
            end
            if (bus_fault) begin
                err <= 1'b1;
            end
            // Outside BURST the counter is held at zero so every burst starts fresh.
            if (!in_burst || beat_ok) begin
                tmo <= '0;
            end else if (!bus_fault) begin
                tmo <= tmo + 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        wbm_cyc_o = in_burst;
        wbm_stb_o = in_burst;
        wbm_we_o  = in_burst && is_wr;
        wbm_adr_o = base + (32'(idx) << 2);
        wbm_sel_o = 4'hF;
        wbm_bte_o = 2'b00;
        wbm_cti_o = 3'b000;
        if (in_burst) begin
            wbm_cti_o = burst_end ? 3'b111 : 3'b010;
        end
        // Look one word ahead on an accepted beat so bufw_q holds the next word in time.
        bufw_addr = idx[BUF_AW-1:0] + BUF_AW'(beat_ok);
        wbm_dat_o = bufw_q;
        bufr_wren = beat_ok && !is_wr;
        bufr_addr = idx[BUF_AW-1:0];
        bufr_data = wbm_dat_i;
    end

endmodule

// File: tb/tb_sd_wb_dma.sv
// tb/tb_sd_wb_dma.sv - table-driven bench for sd_wb_dma
// Each table row is one block transfer against a small Wishbone slave and buffer model.
module tb_sd_wb_dma;

    localparam int BUF_AW = 7;
    localparam int NV     = 10;
    localparam int BIG    = 1 << 30;

    logic              clk_50 = 1'b0;
    logic              reset_n = 1'b0;
    logic              rd_req = 1'b0;
    logic [31:0]       rd_addr = '0;
    logic              wr_req = 1'b0;
    logic [31:0]       wr_addr = '0;
    logic              abort = 1'b0;
    logic              busy, done, err;
    logic [BUF_AW-1:0] bufr_addr;
    logic              bufr_wren;
    logic [31:0]       bufr_data;
    logic [BUF_AW-1:0] bufw_addr;
    logic [31:0]       bufw_q = '0;
    logic [31:0]       wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]        wbm_sel_o;
    logic              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
    logic [2:0]        wbm_cti_o;
    logic [1:0]        wbm_bte_o;

    int          beats = 0;
    int          stall_beat = BIG;
    int          err_beat = -1;
    bit          ack_force = 1'b0;
    logic [31:0] cur_base = '0;
    int          n_vec = 0;
    int          n_bad = 0;

    always #10 clk_50 = ~clk_50;

    sd_wb_dma dut (
        .clk_50(clk_50), .reset_n(reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .wr_req(wr_req), .wr_addr(wr_addr),
        .abort(abort), .busy(busy), .done(done), .err(err),
        .bufr_addr(bufr_addr), .bufr_wren(bufr_wren), .bufr_data(bufr_data),
        .bufw_addr(bufw_addr), .bufw_q(bufw_q),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o)
    );

    // Slave: memory word n holds n; write buffer word n holds 0xA500_0000 | n.
    assign wbm_err_i = wbm_stb_o && (beats == err_beat);
    assign wbm_ack_i = (wbm_stb_o && (beats < stall_beat) && (beats != err_beat)) || ack_force;
    assign wbm_dat_i = (wbm_adr_o - cur_base) >> 2;
    always @(posedge clk_50) bufw_q <= 32'hA500_0000 | 32'(bufw_addr);

    typedef struct {
        string       name;
        bit          is_wr;
        bit          both;
        logic [31:0] addr;
        int          stall;
        int          errb;
        int          abortb;
        int          midrd;
        bit          ackall;
        int          e_beats;
        int          e_wr;
        int          e_done;
        bit          e_err;
        int          e_bursts;
        logic [31:0] e_last;
    } vec_t;

    vec_t vt[NV];

    function automatic vec_t mk(string n, bit w, bit b, logic [31:0] a, int st, int eb, int ab,
                                int mr, bit aa, int xb, int xw, int xd, bit xe, int xbu,
                                logic [31:0] xl);
        vec_t v;
        v.name = n; v.is_wr = w; v.both = b; v.addr = a; v.stall = st; v.errb = eb;
        v.abortb = ab; v.midrd = mr; v.ackall = aa; v.e_beats = xb; v.e_wr = xw;
        v.e_done = xd; v.e_err = xe; v.e_bursts = xbu; v.e_last = xl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int          acc, bad, wr_cnt, done_cnt, bursts, cycles, tail;
        bit          started, ab_done, mid_done, prev_abort, prev_err, cyc_prev;
        logic [31:0] last;
        acc = 0; bad = 0; wr_cnt = 0; done_cnt = 0; bursts = 0; cycles = 0; tail = 0;
        started = 0; ab_done = 0; mid_done = 0; prev_abort = 0; prev_err = 0; cyc_prev = 0;
        last = 32'hDEAD_BEEF;
        cur_base = v.addr & 32'hFFFF_FE00;
        beats = 0; stall_beat = v.stall; err_beat = v.errb; ack_force = v.ackall;
        @(negedge clk_50);
        if (v.is_wr) begin
            wr_req = 1'b1; wr_addr = v.addr;
        end
        if (!v.is_wr || v.both) begin
            rd_req = 1'b1; rd_addr = v.is_wr ? 32'h6000_0000 : v.addr;
        end
        @(negedge clk_50);
        rd_req = 1'b0; wr_req = 1'b0;
        forever begin
            abort = (v.abortb >= 0) && !ab_done && wbm_stb_o && (beats == v.abortb);
            if (abort) ab_done = 1;
            rd_req = (v.midrd >= 0) && !mid_done && wbm_stb_o && (beats == v.midrd);
            rd_addr = 32'h6000_0000;
            if (rd_req) mid_done = 1;
            #1;
            acc = 0;
            if (busy) started = 1;
            done_cnt += int'(done);
            if (wbm_cyc_o && !cyc_prev) bursts++;
            if (prev_abort && (wbm_cyc_o || busy)) bad++;
            if (prev_err && wbm_cyc_o) bad++;
            if (wbm_stb_o !== wbm_cyc_o) bad++;
            if (bufr_wren) begin
                wr_cnt++;
                if (bufr_addr !== beats[6:0] || bufr_data !== 32'(beats)) bad++;
            end
            if (wbm_stb_o && wbm_ack_i && !abort && !wbm_err_i) begin
                acc = 1;
                last = wbm_adr_o;
                if (wbm_adr_o !== cur_base + 32'(beats) * 4 ||
                    wbm_cti_o !== ((beats % 8 == 7) ? 3'b111 : 3'b010) ||
                    wbm_we_o !== v.is_wr || wbm_sel_o !== 4'hF || wbm_bte_o !== 2'b00 ||
                    (v.is_wr && wbm_dat_o !== (32'hA500_0000 | 32'(beats))) ||
                    bufr_wren !== !v.is_wr) begin
                    bad++;
                    $display("note %s beat %0d: adr=%0h cti=%0b we=%0b dat_o=%0h", v.name,
                             beats, wbm_adr_o, wbm_cti_o, wbm_we_o, wbm_dat_o);
                end
            end else if (bufr_wren) begin
                bad++;
            end
            prev_abort = abort;
            prev_err = wbm_stb_o && wbm_err_i && !abort;
            cyc_prev = wbm_cyc_o;
            if (started && !busy) begin
                tail++;
                if (tail > 1 && busy) bad++;
                if (tail >= 6) break;
            end
            cycles++;
            if (cycles > 3000) begin
                chk({v.name, "_cycle_bound"}, 32'(cycles), 32'd3000);
                break;
            end
            @(posedge clk_50);
            #1;
            beats += acc;
            @(negedge clk_50);
        end
        abort = 1'b0; rd_req = 1'b0; ack_force = 1'b0;
        chk({v.name, "_beats"}, 32'(beats), 32'(v.e_beats));
        chk({v.name, "_bufr_writes"}, 32'(wr_cnt), 32'(v.e_wr));
        chk({v.name, "_done_pulses"}, 32'(done_cnt), 32'(v.e_done));
        chk({v.name, "_err"}, 32'(err), 32'(v.e_err));
        chk({v.name, "_bursts"}, 32'(bursts), 32'(v.e_bursts));
        chk({v.name, "_last_adr"}, last, v.e_last);
        chk({v.name, "_beat_rules"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int d_cnt, b_cnt;
        //          name          wr both addr          stall err ab  mid all beats wr  done err bursts last
        vt[0] = mk("wr_full",     1, 0, 32'h1000_0123, BIG,  -1, -1, -1, 0, 128, 0,   1, 0, 16, 32'h1000_01FC);
        vt[1] = mk("rd_full",     0, 0, 32'h2000_0000, BIG,  -1, -1, -1, 0, 128, 128, 1, 0, 16, 32'h2000_01FC);
        vt[2] = mk("rd_stall20",  0, 0, 32'h2000_0000, 20,   -1, -1, -1, 0, 20,  20,  1, 1, 3,  32'h2000_004C);
        vt[3] = mk("wr_err5",     1, 0, 32'h3000_0040, BIG,   5, -1, -1, 0, 5,   0,   1, 1, 1,  32'h3000_0010);
        vt[4] = mk("wr_abort20",  1, 0, 32'h4000_0000, BIG,  -1, 20, -1, 0, 20,  0,   0, 0, 3,  32'h4000_004C);
        vt[5] = mk("rd_wrap",     0, 0, 32'hFFFF_FE00, BIG,  -1, -1, -1, 0, 128, 128, 1, 0, 16, 32'hFFFF_FFFC);
        vt[6] = mk("both_req",    1, 1, 32'h5000_0000, BIG,  -1, -1, 10, 0, 128, 0,   1, 0, 16, 32'h5000_01FC);
        vt[7] = mk("rd_ack_idle", 0, 0, 32'h0000_01FF, BIG,  -1, -1, -1, 1, 128, 128, 1, 0, 16, 32'h0000_01FC);
        vt[8] = mk("rd_stall0",   0, 0, 32'h7000_0000, 0,    -1, -1, -1, 0, 0,   0,   1, 1, 1,  32'hDEAD_BEEF);
        vt[9] = mk("wr_abort0",   1, 0, 32'h9000_0000, BIG,  -1,  0, -1, 0, 0,   0,   0, 0, 1,  32'hDEAD_BEEF);

        repeat (3) @(negedge clk_50);
        #1;
        chk("rst_cyc_stb_we", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_cti_bte_sel", {wbm_cti_o, wbm_bte_o, wbm_sel_o}, 32'h00F);
        chk("rst_flags", {busy, done, err, bufr_wren}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run(vt[i]);
        end

        // Reset pulled in the middle of a burst must drop cyc at once and leave no done.
        beats = 0; stall_beat = BIG; err_beat = -1; cur_base = 32'h8000_0000;
        @(negedge clk_50);
        wr_req = 1'b1; wr_addr = 32'h8000_0000;
        @(negedge clk_50);
        wr_req = 1'b0;
        repeat (4) @(negedge clk_50);
        #1;
        chk("midrst_cyc_before", 32'(wbm_cyc_o), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_cyc_async", 32'(wbm_cyc_o), 32'd0);
        chk("midrst_busy_async", 32'(busy), 32'd0);
        chk("midrst_adr_async", wbm_adr_o, 32'd0);
        @(negedge clk_50);
        reset_n = 1'b1;
        d_cnt = 0; b_cnt = 0;
        repeat (10) begin
            @(negedge clk_50);
            #1;
            d_cnt += int'(done);
            b_cnt += int'(busy);
        end
        chk("midrst_done_after", 32'(d_cnt), 32'd0);
        chk("midrst_busy_after", 32'(b_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
